// File: rtl/add64_mc_ctrl.sv
// -----------------------------------------------------------------------------
// add64_mc_ctrl
//   Multi-cycle sequencing wrapper around a 64-bit Kogge-Stone adder.
//   Operands are captured into registers and held stable at the adder for
//   SETTLE_CYC cycles. The adder outputs are then sampled into result
//   registers and offered on a valid/ready handshake. An accumulate mode
//   feeds the last accepted sum back as operand A. A saturating counter
//   records how many results had a carry-out.
//
//   Parameters
//     SETTLE_CYC  cycles operands are held before the sum is sampled (1..15)
//     CNT_W       width of the carry-out event counter
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   operand pair valid
//     in_ready   block can accept operands (IDLE only)
//     in_a       operand A (ignored when in_acc=1)
//     in_b       operand B
//     in_acc     1: operand A is the accumulator instead of in_a
//     out_valid  result valid
//     out_ready  consumer accepts result
//     out_sum    registered adder sum
//     out_cout   registered adder carry-out
//     acc_q      accumulator (last sampled result)
//     cout_cnt   saturating count of results with carry-out set
//     busy       block is not IDLE
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// add64_ks
//   Combinational 64-bit Kogge-Stone adder with carry-in tied to 0.
//   Ports: sum (64-bit result), cout (carry out of bit 63), a, b (operands).
// -----------------------------------------------------------------------------
module add64_ks (
  output logic [63:0] sum,
  output logic        cout,
  input  logic [63:0] a,
  input  logic [63:0] b
);

  logic [63:0] w_p0;
  logic [63:0] w_g;
  logic [63:0] w_p;

  assign w_p0 = a ^ b;

  // Six prefix levels with spans 1,2,4,...,32. After level k, w_g[i] is the
  // group generate of bits [i : i-2^(k+1)+1]. Shifting in zeros makes groups
  // that reach past bit 0 see a zero carry-in, so no separate carry-in term.
  always_comb begin
    w_g = a & b;
    w_p = w_p0;
    for (int lvl = 0; lvl < 6; lvl++) begin
      w_g = w_g | (w_p & (w_g << (1 << lvl)));
      w_p = w_p & (w_p << (1 << lvl));
    end
  end

  // Carry into bit i is the group generate of bits [i-1:0].
  assign sum  = w_p0 ^ {w_g[62:0], 1'b0};
  assign cout = w_g[63];

endmodule

module add64_mc_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic             out_cout,
  output logic [63:0]      acc_q,
  output logic [CNT_W-1:0] cout_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Settle counter starts at SETTLE_CYC-1 so the sample happens in the
  // SETTLE_CYC-th SETTLE cycle.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_next;

  logic [63:0]      r_a;
  logic [63:0]      r_b;
  logic [3:0]       r_cnt;
  logic [63:0]      r_out_sum;
  logic             r_out_cout;
  logic             r_out_valid;
  logic [63:0]      r_acc;
  logic [CNT_W-1:0] r_cout_cnt;

  logic [63:0]      w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_sample;
  logic             w_release;

  // The adder only ever sees the registered operands, which change solely on
  // the accept edge, so its outputs are settled by the time they are sampled.
  add64_ks u_add (
    .sum  (w_sum),
    .cout (w_cout),
    .a    (r_a),
    .b    (r_b)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_sample     = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand registers and settle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= 64'd0;
      r_b <= 64'd0;
    end else if (w_accept) begin
      r_a <= in_acc ? r_acc : in_a;
      r_b <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == SETTLE) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result, accumulator and carry-out counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_sum  <= 64'd0;
      r_out_cout <= 1'b0;
      r_acc      <= 64'd0;
    end else if (w_sample) begin
      r_out_sum  <= w_sum;
      r_out_cout <= w_cout;
      r_acc      <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout_cnt <= '0;
    end else if (w_sample && w_cout && (r_cout_cnt != CNT_MAX)) begin
      r_cout_cnt <= r_cout_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_sample) begin
      r_out_valid <= 1'b1;
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign acc_q     = r_acc;
  assign cout_cnt  = r_cout_cnt;

endmodule

// File: tb/tb_add64_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add64_mc_ctrl
//   Scoreboard bench for add64_mc_ctrl. Stimulus tasks push the hand-computed
//   expected result when an operand pair is issued; monitor processes pop and
//   compare whenever a DUT raises out_valid. A second instance with CNT_W=2
//   exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_add64_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: SETTLE_CYC=4, CNT_W=8
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_acc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
  logic [63:0] acc_q;
  logic [7:0]  cout_cnt;
  logic        busy;

  // Instance 2: SETTLE_CYC=4, CNT_W=2
  logic        rst2_n;
  logic        in_valid2;
  logic        in_ready2;
  logic [63:0] in_a2;
  logic [63:0] in_b2;
  logic        in_acc2;
  logic        out_valid2;
  logic        out_ready2;
  logic [63:0] out_sum2;
  logic        out_cout2;
  logic [63:0] acc_q2;
  logic [1:0]  cout_cnt2;
  logic        busy2;

  add64_mc_ctrl #(.SETTLE_CYC(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .acc_q(acc_q), .cout_cnt(cout_cnt), .busy(busy)
  );

  add64_mc_ctrl #(.SETTLE_CYC(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_acc(in_acc2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sum(out_sum2), .out_cout(out_cout2),
    .acc_q(acc_q2), .cout_cnt(cout_cnt2), .busy(busy2)
  );

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: one result popped per rising out_valid
  // ---------------------------------------------------------------------------
  logic prev_v1 = 1'b0;
  logic prev_v2 = 1'b0;
  exp_t e1;
  exp_t e2;

  always @(negedge clk) begin
    if (out_valid) chk("dut1_sum_not_x", 64'($isunknown(out_sum)), 64'd0);
    if (out_valid && !prev_v1) begin
      $display("dut1 result sum=%h cout=%b cnt=%0d acc=%h", out_sum, out_cout, cout_cnt, acc_q);
      if (q1.size() == 0) begin
        chk("dut1_unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_sum", out_sum, e1.sum);
        chk("dut1_cout", 64'(out_cout), 64'(e1.cout));
        chk("dut1_cout_cnt", 64'(cout_cnt), 64'(e1.cnt));
        chk("dut1_acc_q", acc_q, e1.sum);
      end
    end
    prev_v1 = out_valid;
  end

  always @(negedge clk) begin
    if (out_valid2 && !prev_v2) begin
      $display("dut2 result sum=%h cout=%b cnt=%0d acc=%h", out_sum2, out_cout2, cout_cnt2, acc_q2);
      if (q2.size() == 0) begin
        chk("dut2_unexpected_result", 64'(out_valid2), 64'd0);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_sum", out_sum2, e2.sum);
        chk("dut2_cout", 64'(out_cout2), 64'(e2.cout));
        chk("dut2_cout_cnt", 64'(cout_cnt2), 64'(e2.cnt));
      end
    end
    prev_v2 = out_valid2;
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send1(input logic [63:0] a, input logic [63:0] b, input logic acc,
                       input logic [63:0] es, input logic ec, input logic [7:0] ecnt);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("dut1_in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    q1.push_back('{sum: es, cout: ec, cnt: ecnt});
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_acc   = acc;
    @(posedge clk);
    // Count cycles after the accept edge until out_valid is seen; the result
    // appears in the 5th cycle (4 SETTLE cycles, then HOLD).
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 20);
    chk("dut1_latency", 64'(n), 64'd5);
    if (out_ready) begin
      @(negedge clk);
      chk("dut1_single_cycle_valid", 64'(out_valid), 64'd0);
    end
  endtask

  task automatic send2(input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] es, input logic ec, input logic [7:0] ecnt);
    int n;
    n = 0;
    while (!in_ready2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready2) begin
      chk("dut2_in_ready_timeout", 64'(in_ready2), 64'd1);
      return;
    end
    q2.push_back('{sum: es, cout: ec, cnt: ecnt});
    in_valid2 = 1'b1;
    in_a2     = a;
    in_b2     = b;
    in_acc2   = 1'b0;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      in_valid2 = 1'b0;
      n++;
    end while (!out_valid2 && n < 20);
    chk("dut2_latency", 64'(n), 64'd5);
    @(negedge clk);
  endtask

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  task automatic run_main();
    int bad;
    send1(64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 8'd0);
    send1(ONES, 64'd1, 1'b0, 64'd0, 1'b1, 8'd1);
    // Accumulate chain
    send1(64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 8'd1);
    send1(JUNK, 64'd5, 1'b1, 64'd35, 1'b0, 8'd1);
    send1(JUNK, 64'd7, 1'b1, 64'd42, 1'b0, 8'd1);
    // Carry-chain patterns
    send1(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
          64'h2222_2222_2222_2211, 1'b0, 8'd1);
    send1(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, ONES, 1'b0, 8'd1);
    send1(ONES, ONES, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 8'd2);

    // Back-pressure: hold the result for 10 cycles, pulse in_valid meanwhile.
    out_ready = 1'b0;
    send1(MSB, 64'h8000_0000_0000_0001, 1'b0, 64'd1, 1'b1, 8'd3);
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_out_sum", out_sum, 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid = (i % 2 == 1);
      in_a     = 64'd77;
      in_b     = 64'd77;
      in_acc   = 1'b0;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", 64'(out_valid), 64'd0);
    chk("hold_release_in_ready", 64'(in_ready), 64'd1);
    // Accumulator must still be 1: the pulses during HOLD were dropped.
    send1(JUNK, 64'd2, 1'b1, 64'd3, 1'b0, 8'd3);

    // Reset in the 2nd SETTLE cycle; nothing is pushed for this operation.
    in_valid = 1'b1;
    in_a     = 64'd100;
    in_b     = 64'd200;
    in_acc   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_out_sum", out_sum, 64'd0);
    chk("rst_mid_acc_q", acc_q, 64'd0);
    chk("rst_mid_cout_cnt", 64'(cout_cnt), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk("rst_no_stale_valid", 64'(bad), 64'd0);
    // First accumulate after reset uses acc_q = 0.
    send1(JUNK, 64'd9, 1'b1, 64'd9, 1'b0, 8'd0);
  endtask

  task automatic run_sat();
    send2(MSB, MSB, 64'd0, 1'b1, 8'd1);
    send2(MSB, MSB, 64'd0, 1'b1, 8'd2);
    send2(MSB, MSB, 64'd0, 1'b1, 8'd3);
    send2(MSB, MSB, 64'd0, 1'b1, 8'd3);
    send2(MSB, MSB, 64'd0, 1'b1, 8'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    rst2_n     = 1'b0;
    in_valid   = 1'b0;
    in_a       = 64'd0;
    in_b       = 64'd0;
    in_acc     = 1'b0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    in_a2      = 64'd0;
    in_b2      = 64'd0;
    in_acc2    = 1'b0;
    out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_sum", out_sum, 64'd0);
    chk("reset_out_cout", 64'(out_cout), 64'd0);
    chk("reset_acc_q", acc_q, 64'd0);
    chk("reset_cout_cnt", 64'(cout_cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    fork
      run_main();
      run_sat();
    join
    repeat (3) @(negedge clk);
    chk("dut1_queue_empty", 64'(q1.size()), 64'd0);
    chk("dut2_queue_empty", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add64_mc_ctrl.md
Name: add64_mc_ctrl

Overview:
- Sequential wrapper feeding and consuming one instance of the team's 64-bit Kogge-Stone adder (ports sum, cout, a, b).
- Registers operands and holds them stable for a programmable number of settle cycles, because the gate-level adder has real propagation delay.
- Captures the sum and carry into output registers and presents them on a valid/ready handshake.
- Provides an accumulate mode (result fed back as operand A) and a saturating carry-out counter for the datapath test harness.

Parameters:
- SETTLE_CYC, 4, cycles operands are held at the adder before the result is sampled; legal range 1..15.
- CNT_W, 8, width of the carry-out event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  64  operand A (ignored when in_acc=1).
- in_b  in  64  operand B.
- in_acc  in  1  1: operand A = accumulator register instead of in_a.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  64  registered adder sum.
- out_cout  out  1  registered adder carry-out.
- acc_q  out  64  accumulator register (last accepted result).
- cout_cnt  out  CNT_W  number of results with cout=1, saturating.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (asynchronous, rst_n=0): state=IDLE, a_reg=b_reg=0, out_sum=0, out_cout=0, out_valid=0, acc_q=0, cout_cnt=0, settle counter=0. in_ready=1 once rst_n is released.
- Reset asserted mid-operation aborts immediately and discards any pending result.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: a_reg<=in_acc?acc_q:in_a, b_reg<=in_b, cnt<=SETTLE_CYC-1, go to SETTLE.
- State SETTLE:
  - in_ready=0; a_reg/b_reg drive the adder and must stay constant.
  - cnt decrements each cycle.
  - In the cycle cnt==0: out_sum<=adder sum, out_cout<=adder cout, acc_q<=adder sum, cout_cnt increments if cout=1 (holds at 2^CNT_W-1), out_valid<=1, go to HOLD.
- State HOLD:
  - out_valid=1; out_sum/out_cout stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in HOLD (no overlap).
- Latency: accept edge to out_valid=1 is SETTLE_CYC+1 cycles.
  - Max throughput is one result per SETTLE_CYC+2 cycles with out_ready held at 1.
- Arithmetic:
  - out_sum = (A+B) mod 2^64; out_cout = bit 64 of the full sum.
  - Carry-in is always 0.
  - The accumulator wraps modulo 2^64; the wrap is flagged only through out_cout and cout_cnt.
- Handshake boundaries:
  - in_valid while busy: ignored; the source must hold its data until in_ready.
  - out_ready held high before out_valid: the result is still presented for exactly one cycle.
  - in_acc=1 as the first operation after reset uses acc_q=0.
- Bus values: the adder outputs must never be sampled outside the cnt==0 cycle. The bench checks for X on out_sum while out_valid=1.

Test Plan:
- Reset, then a=64'h0000_0000_0000_0005, b=64'h0000_0000_0000_0003 -> out_valid rises 5 cycles after acceptance; out_sum=8, out_cout=0, cout_cnt=0.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> out_sum=0, out_cout=1, cout_cnt=1, acc_q=0.
- Accumulate chain: a=10, b=20 (in_acc=0); then b=5 (in_acc=1); then b=7 (in_acc=1) -> out_sum 30, 35, 42.
- out_ready held low 10 cycles in HOLD -> out_sum/out_valid stable, in_ready=0; in_valid pulses during HOLD are dropped.
- rst_n asserted in 2nd SETTLE cycle -> all outputs 0 asynchronously; after release, in_ready=1 and no stale out_valid.
- CNT_W=2, five overflowing adds (a=2^63, b=2^63) -> cout_cnt saturates at 3.
